fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-issue MIPS pipeline. It sits directly upstream of the byte-addressed, big-endian instruction memory. It owns the program counter and drives the memory's word address. It registers the returned instruction into the IF/ID pipeline register for decode, and handles stall, flush and branch/jump redirect from later stages.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents (hazard unit).
- flush  in  1  squash the IF/ID entry (insert bubble).
- redirect  in  1  load redirect_target into PC (taken branch/jump).
- redirect_target  in  32  new PC byte address.
- address  out  32  current PC, driven combinationally from the PC register to instruction memory.
- instruction  in  32  word returned combinationally by instruction memory for address.
- if_id_instruction  out  32  registered instruction to decode.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID entry holds a real instruction.
- fetch_count  out  32  number of valid instructions loaded into IF/ID.
- misaligned  out  1  sticky alignment fault (see Configuration).

## Operation
- States: RUN, TRAP. Reset enters RUN. TRAP exists only with FETCH_ALIGN_CHECK_EN.
- address = pc at all times. pc_plus4 = pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Per-edge priority in RUN (highest first):
  - redirect=1: pc <= redirect_target. IF/ID loads instruction=0 (NOP), pc_plus4=0, valid=0. This applies regardless of stall and flush.
  - flush=1: IF/ID loads 0/0/valid=0. pc <= pc_plus4 if stall=0, else pc is held.
  - stall=1: pc and IF/ID are held unchanged.
  - otherwise: pc <= pc_plus4. IF/ID loads instruction, pc_plus4, valid=1.
- fetch_count increments by 1 on every edge where IF/ID loads valid=1. It wraps at 2^32. A held entry under stall does not count again.
- TRAP: pc, IF/ID and fetch_count are frozen. if_id_valid=0, misaligned=1. Only reset leaves TRAP.

## Timing
- Reset values: pc=RESET_PC (so address=RESET_PC), if_id_instruction=0, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0, misaligned=0, state=RUN.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.
- Fetch latency: an instruction at pc appears on if_id_* one edge after pc is presented.
- Redirect penalty: one bubble. The target's instruction reaches IF/ID on the second edge after redirect is sampled.
- First valid IF/ID entry: first rising edge after reset deasserts with stall=0. It holds the instruction at RESET_PC, with if_id_pc_plus4=RESET_PC+4.
- stall, flush, redirect and redirect_target are sampled only on the rising edge. No combinational path runs from them to address.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_target[1:0] != 2'b00 does not update pc.
  - On that edge, state goes to TRAP, misaligned goes to 1, and if_id_valid goes to 0.
- FETCH_ALIGN_CHECK_EN undefined:
  - pc loads {redirect_target[31:2], 2'b00}.
  - misaligned is tied to 0 and TRAP is not implemented.

## Test plan
- Reset then sequential run: RESET_PC=0, stall/flush/redirect low, memory preloaded with add/sub/and at 0/4/8. Required response:
  - address steps 0, 4, 8, 12.
  - if_id_instruction steps 32'h02324020, 32'h02324822, 32'h02325024.
  - if_id_pc_plus4 steps 4, 8, 12.
  - fetch_count reaches 3.
- Stall for 2 cycles at pc=8: address stays 8, IF/ID holds the word from address 4, fetch_count stays constant. On release, 8 is fetched next.
- Redirect to 32'h0000_0010 while stall=1: pc becomes 0x10 on that edge, if_id_valid drops to 0 for one cycle. The next edge gives if_id_instruction = word at 0x10 and if_id_pc_plus4=0x14.
- Flush with stall both high at pc=12: if_id_valid=0, if_id_instruction=0, address stays 12.
- Wrap: redirect to 32'hFFFF_FFFC, then run two cycles: address goes 32'hFFFF_FFFC then 32'h0000_0000, and if_id_pc_plus4=0.
- Misaligned redirect to 32'h0000_0006:
  - With FETCH_ALIGN_CHECK_EN: misaligned=1, address unchanged, if_id_valid stays 0 until reset; async reset restores address=RESET_PC and misaligned=0.
  - Without FETCH_ALIGN_CHECK_EN: address becomes 4.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives instruction-memory address, fills IF/ID.
// Optional FETCH_ALIGN_CHECK_EN traps on misaligned redirect targets (sticky until reset).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        misaligned
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        run;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic {RUN, TRAP} state_e;
  state_e state_q, state_d;
  logic   mis_q, mis_d;

  assign run        = (state_q == RUN);
  assign misaligned = mis_q;
`else
  assign run        = 1'b1;
  assign misaligned = 1'b0;
`endif

  assign pc_plus4          = pc_q + 32'd4;
  assign address           = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc_plus4    = pcp4_q;
  assign if_id_valid       = valid_q;
  assign fetch_count       = count_q;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    count_d = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    state_d = state_q;
    mis_d   = mis_q;
`endif
    if (run) begin
      if (redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned target freezes the PC and parks the stage in TRAP.
        if (redirect_target[1:0] != 2'b00) begin
          state_d = TRAP;
          mis_d   = 1'b1;
          valid_d = 1'b0;
        end else begin
          pc_d    = redirect_target;
          instr_d = '0;
          pcp4_d  = '0;
          valid_d = 1'b0;
        end
`else
        pc_d    = redirect_target & 32'hFFFF_FFFC;
        instr_d = '0;
        pcp4_d  = '0;
        valid_d = 1'b0;
`endif
      end else if (flush) begin
        instr_d = '0;
        pcp4_d  = '0;
        valid_d = 1'b0;
        if (!stall) pc_d = pc_plus4;
      end else if (!stall) begin
        pc_d    = pc_plus4;
        instr_d = instruction;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      state_q <= RUN;
      mis_q   <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
`ifdef FETCH_ALIGN_CHECK_EN
      state_q <= state_d;
      mis_q   <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/flush/redirect
// traffic compared against a behavioural pipeline model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect;
  logic [31:0] redirect_target;
  logic [31:0] address;
  logic [31:0] instruction;
  logic [31:0] if_id_instruction, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, misaligned;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ins, m_p4, m_cnt;
  logic        m_valid, m_mis, m_trap;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_target(redirect_target), .address(address), .instruction(instruction),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count), .misaligned(misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0232_4020;
      32'h0000_0004: return 32'h0232_4822;
      32'h0000_0008: return 32'h0232_5024;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endcase
  endfunction

  assign instruction = mem_word(address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".address"}, address, m_pc);
    chk({tag, ".instr"}, if_id_instruction, m_ins);
    chk({tag, ".pc_plus4"}, if_id_pc_plus4, m_p4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".count"}, fetch_count, m_cnt);
    chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ins = 0; m_p4 = 0; m_valid = 0; m_cnt = 0; m_mis = 0; m_trap = 0;
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic rd, input logic [31:0] tg);
    if (m_trap) return;
    if (rd) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (tg % 4 != 0) begin
        m_trap = 1; m_mis = 1; m_valid = 0;
        return;
      end
`endif
      m_pc = tg - (tg % 4);
      m_ins = 0; m_p4 = 0; m_valid = 0;
    end else if (fl) begin
      m_ins = 0; m_p4 = 0; m_valid = 0;
      if (!st) m_pc = m_pc + 4;
    end else if (!st) begin
      m_ins = mem_word(m_pc);
      m_p4 = m_pc + 4;
      m_valid = 1;
      m_cnt = m_cnt + 1;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic step(input string tag, input logic st, input logic fl, input logic rd,
                      input logic [31:0] tg);
    stall = st; flush = fl; redirect = rd; redirect_target = tg;
    model_edge(st, fl, rd, tg);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; stall = 0; flush = 0; redirect = 0; redirect_target = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Sequential run then 2-cycle stall at pc=8
    step("seq0", 0, 0, 0, 0);
    chk("seq0.word", if_id_instruction, 32'h0232_4020);
    step("seq1", 0, 0, 0, 0);
    chk("seq1.word", if_id_instruction, 32'h0232_4822);
    step("stall0", 1, 0, 0, 0);
    step("stall1", 1, 0, 0, 0);
    chk("stall.addr", address, 32'd8);
    step("seq2", 0, 0, 0, 0);
    chk("seq2.word", if_id_instruction, 32'h0232_5024);
    chk("seq2.count", fetch_count, 32'd3);
    chk("seq2.addr", address, 32'd12);

    // Redirect under stall, then target fetched
    step("redir_stall", 1, 0, 1, 32'h10);
    step("redir_fetch", 0, 0, 0, 0);
    chk("redir.p4", if_id_pc_plus4, 32'h14);

    // Flush with stall at pc=12
    step("to12", 0, 0, 1, 32'hC);
    step("flush_stall", 1, 1, 0, 0);
    chk("flush_stall.addr", address, 32'd12);

    // Wrap at top of address space
    step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap0", 0, 0, 0, 0);
    chk("wrap.addr", address, 32'd0);
    chk("wrap.p4", if_id_pc_plus4, 32'd0);
    step("wrap1", 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic st, fl, rd;
      logic [31:0] tg;
      st = ($urandom_range(3) == 0);
      fl = ($urandom_range(7) == 0);
      rd = ($urandom_range(7) == 0);
      tg = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      tg = tg & 32'hFFFF_FFFC;
`endif
      step("rand", st, fl, rd, tg);
    end

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step("post_reset", 0, 0, 0, 0);

    // Misaligned redirect
    step("mis_redir", 0, 0, 1, 32'h6);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis.flag", {31'd0, misaligned}, 32'd1);
    step("trap0", 0, 0, 0, 0);
    step("trap1", 0, 0, 1, 32'h20);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("trap_reset");
    @(negedge clk);
    reset = 1'b0;
`else
    chk("mis.addr", address, 32'd4);
    step("mis_fetch", 0, 0, 0, 0);
`endif
    step("final", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
